// File: rtl/soc_ctrl_boot_seq.sv
// Boot sequencer: bus initiator toward soc_ctrl_reg_if. It programs the PLLs, waits for lock,
// releases the link clocks/resets and then the enabled cores, and reports done or the failing step.
module soc_ctrl_boot_seq #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int POLL_GAP   = 4,
    parameter int POLL_LIMIT = 1024,
    parameter int REF_DIV_BW = 4,
    parameter int FB_DIV_BW  = 12
) (
    input  logic                    arst_ni,
    input  logic                    clk_i,
    input  logic                    start_i,
    input  logic [1:0]              core_en_i,
    input  logic [REF_DIV_BW-1:0]   core_pll_ref_div_i,
    input  logic [FB_DIV_BW-1:0]    core_pll_fb_div_i,
    input  logic [REF_DIV_BW-1:0]   sys_pll_ref_div_i,
    input  logic [FB_DIV_BW-1:0]    sys_pll_fb_div_i,
    output logic                    mem_we_o,
    output logic [ADDR_WIDTH-1:0]   mem_waddr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
    input  logic [1:0]              mem_wresp_i,
    output logic                    mem_re_o,
    output logic [ADDR_WIDTH-1:0]   mem_raddr_o,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic [1:0]              mem_rresp_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [3:0]              err_step_o
);

    localparam int CFG_W    = REF_DIV_BW + FB_DIV_BW;
    localparam int LOCK_BIT = CFG_W;
    localparam int GW       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int PW       = $clog2(POLL_LIMIT + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [PW-1:0] POLL_MAX = PW'(POLL_LIMIT);

    localparam logic [ADDR_WIDTH-1:0] REG_PLL_CONFIG_CORE_0_ADDR   = ADDR_WIDTH'(32'h00);
    localparam logic [ADDR_WIDTH-1:0] REG_PLL_CONFIG_CORE_1_ADDR   = ADDR_WIDTH'(32'h04);
    localparam logic [ADDR_WIDTH-1:0] REG_PLL_CONFIG_SYS_LINK_ADDR = ADDR_WIDTH'(32'h08);
    localparam logic [ADDR_WIDTH-1:0] REG_CLK_RST_SYS_LINK_ADDR    = ADDR_WIDTH'(32'h0C);
    localparam logic [ADDR_WIDTH-1:0] REG_CLK_RST_PERIPH_LINK_ADDR = ADDR_WIDTH'(32'h10);
    localparam logic [ADDR_WIDTH-1:0] REG_CLK_RST_CORE_LINK_ADDR   = ADDR_WIDTH'(32'h14);
    localparam logic [ADDR_WIDTH-1:0] REG_CLK_RST_CORE_0_ADDR      = ADDR_WIDTH'(32'h18);
    localparam logic [ADDR_WIDTH-1:0] REG_CLK_RST_CORE_1_ADDR      = ADDR_WIDTH'(32'h1C);

    typedef enum logic [2:0] {IDLE, SEQ, GAP, DONE, ERROR} state_e;

    state_e           state_q, state_d;
    logic [3:0]       step_q, step_d, nxt_step, err_step_q, err_step_d;
    logic [PW-1:0]    poll_q, poll_d, poll_inc;
    logic [GW-1:0]    gap_q, gap_d;
    logic [1:0]       core_en_q;
    logic [CFG_W-1:0] core_cfg_q, sys_cfg_q;
    logic             load;
    logic             is_poll;
    logic [ADDR_WIDTH-1:0] step_addr;
    logic [DATA_WIDTH-1:0] step_data;
    logic             unused_rdata;

    assign unused_rdata = ^mem_rdata_i;
    assign is_poll  = (step_q >= 4'd3) && (step_q <= 4'd5);
    assign poll_inc = poll_q + PW'(1);

    // Disabled core releases are skipped without spending a cycle; 11 means nothing left.
    always_comb begin
        nxt_step = step_q + 4'd1;
        if (nxt_step == 4'd9 && !core_en_q[0]) nxt_step = 4'd10;
        if (nxt_step == 4'd10 && !core_en_q[1]) nxt_step = 4'd11;
    end

    always_comb begin
        step_addr = REG_CLK_RST_CORE_1_ADDR;
        case (step_q)
            4'd0, 4'd3: step_addr = REG_PLL_CONFIG_CORE_0_ADDR;
            4'd1, 4'd4: step_addr = REG_PLL_CONFIG_CORE_1_ADDR;
            4'd2, 4'd5: step_addr = REG_PLL_CONFIG_SYS_LINK_ADDR;
            4'd6:       step_addr = REG_CLK_RST_SYS_LINK_ADDR;
            4'd7:       step_addr = REG_CLK_RST_PERIPH_LINK_ADDR;
            4'd8:       step_addr = REG_CLK_RST_CORE_LINK_ADDR;
            4'd9:       step_addr = REG_CLK_RST_CORE_0_ADDR;
            default:    step_addr = REG_CLK_RST_CORE_1_ADDR;
        endcase
        step_data = DATA_WIDTH'(32'd3);
        case (step_q)
            4'd0, 4'd1: step_data = DATA_WIDTH'(core_cfg_q);
            4'd2:       step_data = DATA_WIDTH'(sys_cfg_q);
            default:    step_data = DATA_WIDTH'(32'd3);
        endcase
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        poll_d      = poll_q;
        gap_d       = gap_q;
        err_step_d  = err_step_q;
        load        = 1'b0;
        mem_we_o    = 1'b0;
        mem_waddr_o = '0;
        mem_wdata_o = '0;
        mem_wstrb_o = '0;
        mem_re_o    = 1'b0;
        mem_raddr_o = '0;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start_i) begin
                    state_d    = SEQ;
                    step_d     = 4'd0;
                    poll_d     = '0;
                    gap_d      = '0;
                    err_step_d = 4'd0;
                    load       = 1'b1;
                end
            end
            SEQ: begin
                if (is_poll) begin
                    mem_re_o    = 1'b1;
                    mem_raddr_o = step_addr;
                    if (mem_rresp_i != 2'b00) begin
                        state_d    = ERROR;
                        err_step_d = step_q;
                    end else if (mem_rdata_i[LOCK_BIT]) begin
                        poll_d = '0;
                        step_d = nxt_step;
                    end else if (poll_inc == POLL_MAX) begin
                        state_d    = ERROR;
                        err_step_d = step_q;
                    end else begin
                        poll_d = poll_inc;
                        gap_d  = '0;
                        if (POLL_GAP > 0) state_d = GAP;
                    end
                end else begin
                    mem_we_o    = 1'b1;
                    mem_waddr_o = step_addr;
                    mem_wdata_o = step_data;
                    mem_wstrb_o = '1;
                    if (mem_wresp_i != 2'b00) begin
                        state_d    = ERROR;
                        err_step_d = step_q;
                    end else if (nxt_step == 4'd11) begin
                        state_d = DONE;
                    end else begin
                        step_d = nxt_step;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) state_d = SEQ;
                else                   gap_d   = gap_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q    <= IDLE;
            step_q     <= 4'd0;
            poll_q     <= '0;
            gap_q      <= '0;
            err_step_q <= 4'd0;
            core_en_q  <= 2'b00;
            core_cfg_q <= '0;
            sys_cfg_q  <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            poll_q     <= poll_d;
            gap_q      <= gap_d;
            err_step_q <= err_step_d;
            if (load) begin
                core_en_q  <= core_en_i;
                core_cfg_q <= {core_pll_fb_div_i, core_pll_ref_div_i};
                sys_cfg_q  <= {sys_pll_fb_div_i, sys_pll_ref_div_i};
            end
        end
    end

    assign busy_o     = (state_q == SEQ) || (state_q == GAP);
    assign done_o     = (state_q == DONE);
    assign error_o    = (state_q == ERROR);
    assign err_step_o = err_step_q;

endmodule

// File: tb/tb_soc_ctrl_boot_seq.sv
// Directed bench for soc_ctrl_boot_seq with a combinational register responder whose PLLs
// lock after a programmable number of reads.
module tb_soc_ctrl_boot_seq;

    logic        clk_i = 1'b0;
    logic        arst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  core_en_i = 2'b11;
    logic [3:0]  core_pll_ref_div_i = 4'h2;
    logic [11:0] core_pll_fb_div_i = 12'h040;
    logic [3:0]  sys_pll_ref_div_i = 4'h1;
    logic [11:0] sys_pll_fb_div_i = 12'h020;
    logic        mem_we_o, mem_re_o;
    logic [7:0]  mem_waddr_o, mem_raddr_o;
    logic [31:0] mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_wstrb_o;
    logic [1:0]  mem_wresp_i, mem_rresp_i;
    logic        busy_o, done_o, error_o;
    logic [3:0]  err_step_o;

    int          lock_at [3] = '{1, 1, 1};
    int          rd_cnt  [3];
    int          ridx;
    logic        rd_locked;
    logic        werr_en = 1'b0;
    logic [7:0]  werr_addr = 8'h00;

    int          cyc = 0;
    int          kc = 0;
    int          n0 = 0;
    int          errors = 0;
    int          checks = 0;
    int          rel;
    int          cnt;
    logic [55:0] got;

    int          l_cyc  [$];
    logic        l_we   [$];
    logic [7:0]  l_addr [$];
    logic [31:0] l_data [$];
    logic [3:0]  l_strb [$];

    soc_ctrl_boot_seq #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .POLL_GAP(4), .POLL_LIMIT(8)) dut (
        .arst_ni(arst_ni), .clk_i(clk_i), .start_i(start_i), .core_en_i(core_en_i),
        .core_pll_ref_div_i(core_pll_ref_div_i), .core_pll_fb_div_i(core_pll_fb_div_i),
        .sys_pll_ref_div_i(sys_pll_ref_div_i), .sys_pll_fb_div_i(sys_pll_fb_div_i),
        .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_wresp_i(mem_wresp_i), .mem_re_o(mem_re_o),
        .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata_i), .mem_rresp_i(mem_rresp_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .err_step_o(err_step_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Responder: unlocked reads return every bit except the lock bit set.
    assign ridx        = (mem_raddr_o == 8'h04) ? 1 : (mem_raddr_o == 8'h08) ? 2 : 0;
    assign rd_locked   = (lock_at[ridx] != 0) && (rd_cnt[ridx] + 1 >= lock_at[ridx]);
    assign mem_rdata_i = !mem_re_o ? 32'h0 : rd_locked ? 32'h0001_0000 : 32'hFFFE_FFFF;
    assign mem_rresp_i = 2'b00;
    assign mem_wresp_i = (werr_en && mem_we_o && mem_waddr_o == werr_addr) ? 2'b10 : 2'b00;

    always @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni)      rd_cnt <= '{0, 0, 0};
        else if (start_i)  rd_cnt <= '{0, 0, 0};
        else if (mem_re_o) rd_cnt[ridx] <= rd_cnt[ridx] + 1;
    end

    always @(negedge clk_i) begin
        if (mem_we_o || mem_re_o) begin
            l_cyc.push_back(cyc);
            l_we.push_back(mem_we_o);
            l_addr.push_back(mem_raddr_o | mem_waddr_o);
            l_data.push_back(mem_wdata_o);
            l_strb.push_back(mem_wstrb_o);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_seq(input logic [1:0] en, input int l0, input int l1, input int l2);
        @(negedge clk_i);
        core_en_i = en;
        lock_at   = '{l0, l1, l2};
        start_i   = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        kc = cyc;
        n0 = l_cyc.size();
    endtask

    // Relative cycle (k+rel) at which done_o or error_o is first seen; -1 if the bound expires.
    task automatic wait_end(output int r);
        r = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (done_o || error_o) begin
                r = cyc - kc + 1;
                break;
            end
        end
    endtask

    task automatic entry(input int i, output logic [55:0] e);
        if (n0 + i < l_cyc.size())
            e = {8'(l_cyc[n0+i] - kc + 1), 7'b0, l_we[n0+i], l_addr[n0+i], l_data[n0+i]};
        else
            e = '1;
    endtask

    logic [7:0]  exp_addr [11] = '{8'h00, 8'h04, 8'h08, 8'h00, 8'h04, 8'h08,
                                   8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C};
    logic        exp_we   [11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] exp_data [11] = '{32'h402, 32'h402, 32'h201, 32'h0, 32'h0, 32'h0,
                                   32'h3, 32'h3, 32'h3, 32'h3, 32'h3};

    initial begin
        repeat (3) @(negedge clk_i);
        chk("rst_outs", {busy_o, done_o, error_o, err_step_o, mem_we_o, mem_re_o, mem_wstrb_o},
            14'h0);
        arst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("idle_no_start", {busy_o, done_o, mem_we_o, mem_re_o}, 4'h0);

        // Nominal boot
        start_seq(2'b11, 1, 1, 1);
        chk("nom_busy", busy_o, 1'b1);
        wait_end(rel);
        chk("nom_done_cyc", rel, 12);
        chk("nom_flags", {busy_o, done_o, error_o, err_step_o}, 7'b0100000);
        chk("nom_count", l_cyc.size() - n0, 11);
        for (int i = 0; i < 11; i++) begin
            entry(i, got);
            chk($sformatf("nom_acc%0d", i), got, {8'(i + 1), 7'b0, exp_we[i], exp_addr[i], exp_data[i]});
        end
        chk("nom_strb", {l_strb[n0], l_strb[n0+3]}, 8'hF0);

        // Lock delay on core-1 PLL, restarted from DONE
        start_seq(2'b11, 1, 3, 1);
        chk("restart_done_low", {done_o, busy_o}, 2'b01);
        wait_end(rel);
        chk("lock_done_cyc", rel, 22);
        cnt = 0;
        for (int i = n0; i < l_cyc.size(); i++)
            if (!l_we[i] && l_addr[i] == 8'h04) begin
                chk($sformatf("lock_rd%0d_cyc", cnt), l_cyc[i] - kc + 1, 5 + 5 * cnt);
                cnt++;
            end
        chk("lock_rd_count", cnt, 3);
        chk("lock_total", l_cyc.size() - n0, 13);

        // Timeout on sys PLL
        start_seq(2'b11, 1, 1, 0);
        wait_end(rel);
        chk("to_err_cyc", rel, 42);
        chk("to_flags", {busy_o, done_o, error_o, err_step_o}, 7'b0010101);
        cnt = 0;
        for (int i = n0; i < l_cyc.size(); i++)
            if (!l_we[i] && l_addr[i] == 8'h08) cnt++;
        chk("to_sys_reads", cnt, 8);
        cnt = 0;
        for (int i = n0; i < l_cyc.size(); i++)
            if (l_we[i]) cnt++;
        chk("to_writes", cnt, 3);

        // Slave error on the periph-link write
        werr_en   = 1'b1;
        werr_addr = 8'h10;
        start_seq(2'b11, 1, 1, 1);
        chk("serr_errstep_clr", {error_o, err_step_o}, 5'h0);
        wait_end(rel);
        chk("serr_err_cyc", rel, 9);
        chk("serr_flags", {done_o, error_o, err_step_o}, 6'b010111);
        repeat (5) @(negedge clk_i);
        chk("serr_no_more", l_cyc.size() - n0, 8);
        chk("serr_held", {error_o, err_step_o}, 5'b10111);
        werr_en = 1'b0;

        // Only core 0 enabled, then restart from DONE
        start_seq(2'b01, 1, 1, 1);
        chk("en01_err_clr", {error_o, err_step_o}, 5'h0);
        wait_end(rel);
        chk("en01_done_cyc", rel, 11);
        chk("en01_count", l_cyc.size() - n0, 10);
        entry(9, got);
        chk("en01_last", got, {8'd10, 7'b0, 1'b1, 8'h18, 32'h3});
        start_seq(2'b01, 1, 1, 1);
        chk("en01_rst_done_low", done_o, 1'b0);
        wait_end(rel);
        chk("en01_again_cyc", rel, 11);

        // No cores enabled
        start_seq(2'b00, 1, 1, 1);
        wait_end(rel);
        chk("en00_done_cyc", rel, 10);
        chk("en00_count", l_cyc.size() - n0, 9);

        // Reset while waiting in the poll gap
        start_seq(2'b11, 1, 0, 1);
        repeat (6) @(negedge clk_i);
        chk("gap_state", {busy_o, mem_re_o, mem_we_o}, 3'b100);
        arst_ni = 1'b0;
        #1;
        chk("mid_rst_outs", {busy_o, done_o, error_o, err_step_o, mem_we_o, mem_re_o, mem_wstrb_o},
            14'h0);
        cnt = l_cyc.size();
        repeat (2) @(negedge clk_i);
        arst_ni = 1'b1;
        repeat (5) @(negedge clk_i);
        chk("post_rst_idle", {busy_o, done_o, error_o}, 3'b000);
        chk("post_rst_no_acc", l_cyc.size(), cnt);
        start_seq(2'b11, 1, 1, 1);
        wait_end(rel);
        chk("post_rst_boot", rel, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
